clk_wiz_reset_seq: RTL
======================

# clk_wiz_reset_seq

Reset/lock supervisor for the `clk_wiz_0` phase-clock generator. Runs on the free-running input reference clock, drives the wizard's `reset` pin with a timed pulse, watches its asynchronous `locked` output and reports when the phase clocks are usable. Retries on lock timeout and re-sequences on lock loss. Downstream reset bridges for the `clk_p*`/`clk_n*` domains qualify on `clocks_ready`.

## Interface
- `RST_PULSE_CYCLES`, 16: cycles `mmcm_reset` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before retry (≥2).
- `STABLE_CYCLES`, 256: consecutive synchronized-locked cycles required before ready (≥1).
- `MAX_RETRIES`, 7: failed attempts before FAULT (1..15).

Ports:
- `clk`  in  1  reference clock (same net as the wizard's `clk_in1`); one clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high block reset.
- `mmcm_locked`  in  1  wizard `locked`, asynchronous to `clk`.
- `force_resync`  in  1  single-cycle request to restart the sequence.
- `mmcm_reset`  out  1  to wizard `reset`.
- `clocks_ready`  out  1  phase clocks locked and stable.
- `fault`  out  1  retries exhausted.
- `retry_count`  out  4  failed attempts in current sequence.
- `relock_count`  out  8  lock-loss events while READY, saturating at 255.

## Operation
- `mmcm_locked` passes through a 2-flop synchronizer → `locked_s`.
- States: ASSERT, WAIT_LOCK, STABLE, READY, FAULT. One cycle counter shared by ASSERT/WAIT_LOCK/STABLE, cleared on every state entry.
- Reset: state=ASSERT, counter=0, `mmcm_reset`=1, `clocks_ready`=0, `fault`=0, `retry_count`=0, `relock_count`=0, sync flops 0.
- ASSERT: `mmcm_reset`=1; after RST_PULSE_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: `mmcm_reset`=0; `locked_s`=1 → STABLE; counter reaches LOCK_TIMEOUT_CYCLES-1 with `locked_s`=0 → `retry_count`+1, then FAULT if new count == MAX_RETRIES else ASSERT. `locked_s` wins over timeout on the same cycle.
- STABLE: `locked_s`=0 → WAIT_LOCK (timer restarts, no retry increment); STABLE_CYCLES consecutive `locked_s`=1 cycles → READY.
- READY: `clocks_ready`=1; `retry_count` cleared on entry; `locked_s`=0 → `relock_count`+1 (saturating) and → ASSERT.
- FAULT: `mmcm_reset`=1, `fault`=1; held until `reset` or `force_resync`.
- `force_resync` (any state) → ASSERT next cycle; clears `retry_count` and `fault`. Beats lock loss in READY on the same cycle; `relock_count` not incremented.
- `reset` mid-sequence: immediate return to reset values, counters included.

## Timing
- All outputs are registered decodes of state/counters; no combinational input→output path.
- `mmcm_reset` high for exactly RST_PULSE_CYCLES cycles per attempt.
- `mmcm_locked` sampled 1 at edge t (held): `locked_s`=1 at t+2, STABLE at t+3, `clocks_ready` rises at edge t+3+STABLE_CYCLES.
- `mmcm_locked` sampled 0 at edge t while READY: `clocks_ready` falls at edge t+3, `mmcm_reset` rises same edge.
- Lock glitches shorter than one `clk` period may be missed; that is accepted.

## Structure
- `clocks_pkg`: state enum `seq_state_t`, default parameter constants, counter width function (`$clog2` of max of the three cycle parameters).
- Sub-module `sync_2ff` (1-bit, reset to 0), reused by downstream reset bridges.
- Single FSM + counter process in `clk_wiz_reset_seq`.

## Test plan
Parameters RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Reset released, `mmcm_locked` rises 10 cycles after `mmcm_reset` falls → `mmcm_reset` high exactly 4 cycles; `clocks_ready` rises 11 edges after lock sampled; counts 0.
- `mmcm_locked` held 0 → two 4-cycle reset pulses 32 cycles apart, then `fault`=1, `retry_count`=2, `mmcm_reset`=1 held.
- In READY, drop `mmcm_locked` for 5 cycles → `clocks_ready` low 3 edges later, `relock_count`=1, new 4-cycle pulse, ready again after relock.
- Lock toggles low for 1 sampled cycle during STABLE → returns to WAIT_LOCK, no retry increment, ready delayed by full 8-cycle stable window.
- `force_resync` in FAULT → `fault`=0, `retry_count`=0, 4-cycle pulse; `force_resync` coincident with lock loss in READY → `relock_count` unchanged.
- `reset` asserted during WAIT_LOCK with `retry_count`=1 → all outputs to reset values next edge, sequence restarts.

Source files
------------

// File: rtl/clocks_pkg.sv
// ============================================================================
// Module   : clocks_pkg
// Purpose  : Shared types, defaults and helpers for the clk_wiz reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clocks_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    localparam int unsigned c_def_rst_pulse_cycles    = 16;
    localparam int unsigned c_def_lock_timeout_cycles = 65536;
    localparam int unsigned c_def_stable_cycles       = 256;
    localparam int unsigned c_def_max_retries         = 7;

    // The shared counter only has to reach (largest window - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchronizer with synchronous reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/clk_wiz_reset_seq.sv
// ============================================================================
// Module   : clk_wiz_reset_seq
// Purpose  : Reset/lock supervisor for clk_wiz_0 with retry, fault and relock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_wiz_reset_seq
    import clocks_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = c_def_rst_pulse_cycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = c_def_lock_timeout_cycles,
    parameter int unsigned STABLE_CYCLES       = c_def_stable_cycles,
    parameter int unsigned MAX_RETRIES         = c_def_max_retries
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mmcm_locked,
    input  logic       force_resync,
    output logic       mmcm_reset,
    output logic       clocks_ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] relock_count
);

    localparam int unsigned c_cnt_w = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                                STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stb_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [3:0]         c_retry_max = 4'(MAX_RETRIES);

    logic               locked_s;
    seq_state_t         state_d, state_q;
    logic [c_cnt_w-1:0] cnt_d, cnt_q;
    logic [3:0]         retry_d, retry_q;
    logic [7:0]         relock_d, relock_q;
    logic               mmcm_reset_d, mmcm_reset_q;
    logic               ready_d, ready_q;
    logic               fault_d, fault_q;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .i_d (mmcm_locked),
        .o_q (locked_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + c_cnt_one;
        retry_d  = retry_q;
        relock_d = relock_q;

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == c_rst_last) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = c_cnt_zero;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = c_cnt_zero;
                end else if (cnt_q == c_tmo_last) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == c_retry_max) ? ST_FAULT : ST_ASSERT;
                    cnt_d   = c_cnt_zero;
                end
            end
            ST_STABLE: begin
                // A dropout here is treated as "not locked yet", not a failed attempt.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = c_cnt_zero;
                end else if (cnt_q == c_stb_last) begin
                    state_d = ST_READY;
                    cnt_d   = c_cnt_zero;
                    retry_d = 4'd0;
                end
            end
            ST_READY: begin
                cnt_d = c_cnt_zero;
                if (!locked_s) begin
                    state_d = ST_ASSERT;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            ST_FAULT: begin
                cnt_d = c_cnt_zero;
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = c_cnt_zero;
            end
        endcase

        // Resync overrides everything, including a same-cycle lock loss in READY.
        if (force_resync) begin
            state_d  = ST_ASSERT;
            cnt_d    = c_cnt_zero;
            retry_d  = 4'd0;
            relock_d = relock_q;
        end

        mmcm_reset_d = (state_q == ST_ASSERT) || (state_q == ST_FAULT);
        ready_d      = (state_q == ST_READY);
        fault_d      = (state_q == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= c_cnt_zero;
            retry_q      <= 4'd0;
            relock_q     <= 8'd0;
            mmcm_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            mmcm_reset_q <= mmcm_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign mmcm_reset   = mmcm_reset_q;
    assign clocks_ready = ready_q;
    assign fault        = fault_q;
    assign retry_count  = retry_q;
    assign relock_count = relock_q;

endmodule

`default_nettype wire
